// File: rtl/tvbg_pkg.sv
// Shared types and constants for the TV-code playback sequencer.
// Watchdog support is built only when TVBG_SEQ_WATCHDOG_EN is defined.
package tvbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_RUN,
    S_RECOVER,
    S_GAP,
    S_DONE
  } e_seq_state;

  localparam int WAIT_BUSY_TIMEOUT = 4;
  localparam int RECOVER_CYCLES = 2;
  localparam logic [7:0] FAIL_COUNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == FAIL_COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/tvbg_sequencer_gap_timer.sv
// Load/count/expire down-counter; expired is the terminal-count compare.
// Used for the per-state phase timing and for the optional run watchdog.
module tvbg_gap_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_en && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/tvbg_sequencer.sv
// Session scheduler for the TV-code controller: region offset, repeated sweeps, recovery.
// Optional stuck-run watchdog enabled by defining TVBG_SEQ_WATCHDOG_EN.
//
// state       | meaning
// S_IDLE      | waiting for a trigger rising edge
// S_START     | one-cycle start pulse to the controller
// S_WAIT_BUSY | waiting up to 4 cycles for controller busy
// S_RUN       | sweep in progress, LED on
// S_RECOVER   | controller held in reset for 2 cycles
// S_GAP       | silent gap before the next sweep
// S_DONE      | waiting for controller idle, then done strobe
module tvbg_sequencer
  import tvbg_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 13,
  parameter logic [ADDRESS_BITS-1:0] REGION0_BASE = 13'h0000,
  parameter logic [ADDRESS_BITS-1:0] REGION1_BASE = 13'h1000,
  parameter int                      GAP_BITS     = 24,
  parameter logic [GAP_BITS-1:0]     GAP_CYCLES   = 24'd1_000_000,
  parameter int                      REPEAT_BITS  = 4
`ifdef TVBG_SEQ_WATCHDOG_EN
  , parameter int                    WDOG_BITS    = 28
`endif
) (
  input  logic                    clock_in,
  input  logic                    reset_n_in,
  input  logic                    trigger_in,
  input  logic                    abort_in,
  input  logic                    region_sel_in,
  input  logic [REPEAT_BITS-1:0]  repeat_count_in,
  output logic                    ctrl_reset_out,
  output logic                    ctrl_start_out,
  output logic                    ctrl_loop_forever_out,
  input  logic                    ctrl_busy_in,
  input  logic                    ctrl_fail_in,
  input  logic [ADDRESS_BITS-1:0] ctrl_address_in,
  output logic [ADDRESS_BITS-1:0] mem_address_out,
  output logic                    busy_out,
  output logic                    led_out,
  output logic                    done_strobe_out,
  output logic [7:0]              fail_count_out
);

  e_seq_state state_q, state_next;

  logic                    trigger_prev_q;
  logic                    trigger_rise;
  logic                    rst_hold_q;
  logic [ADDRESS_BITS-1:0] base_q;
  logic [REPEAT_BITS-1:0]  remaining_q;
  logic [7:0]              fail_count_q;

  logic                    abort_hit;
  logic                    fail_event;
  logic                    sweep_done;
  logic                    last_sweep;

  logic                    phase_load;
  logic [GAP_BITS-1:0]     phase_load_value;
  logic                    phase_expired;
  logic                    wdog_expired;

  assign trigger_rise = trigger_in & ~trigger_prev_q;
  assign abort_hit    = abort_in && (state_q != S_IDLE) && (state_q != S_DONE);
  assign last_sweep   = (remaining_q <= REPEAT_BITS'(1));

  // Every state that needs timing gets its own reload on entry.
  assign phase_load = (state_next != state_q);

  always_comb begin
    phase_load_value = '0;
    case (state_next)
      S_WAIT_BUSY: phase_load_value = GAP_BITS'(WAIT_BUSY_TIMEOUT - 1);
      S_RECOVER:   phase_load_value = GAP_BITS'(RECOVER_CYCLES - 1);
      S_GAP:       phase_load_value = GAP_CYCLES - GAP_BITS'(1);
      default:     phase_load_value = '0;
    endcase
  end

  tvbg_gap_timer #(
    .WIDTH (GAP_BITS)
  ) u_phase_timer (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .load       (phase_load),
    .load_value (phase_load_value),
    .count_en   (1'b1),
    .expired    (phase_expired)
  );

`ifdef TVBG_SEQ_WATCHDOG_EN
  logic wdog_load;
  logic wdog_run;

  // Down-count from all-ones so terminal count matches an up-counter hitting all-ones.
  assign wdog_load = (state_next == S_RUN) && (state_q != S_RUN);
  assign wdog_run  = (state_q == S_RUN);

  tvbg_gap_timer #(
    .WIDTH (WDOG_BITS)
  ) u_wdog_timer (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .load       (wdog_load),
    .load_value ({WDOG_BITS{1'b1}}),
    .count_en   (wdog_run),
    .expired    (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    fail_event = 1'b0;
    sweep_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger_rise) state_next = S_START;
      end
      S_START: begin
        state_next = abort_in ? S_RECOVER : S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (abort_in) begin
          state_next = S_RECOVER;
        end else if (ctrl_busy_in) begin
          state_next = S_RUN;
        end else if (phase_expired) begin
          state_next = S_RECOVER;
          fail_event = 1'b1;
        end
      end
      S_RUN: begin
        if (abort_in) begin
          state_next = S_RECOVER;
        end else if (ctrl_fail_in || wdog_expired) begin
          state_next = S_RECOVER;
          fail_event = 1'b1;
        end else if (!ctrl_busy_in) begin
          sweep_done = 1'b1;
          state_next = last_sweep ? S_DONE : S_GAP;
        end
      end
      S_RECOVER: begin
        // An abort arriving here cuts the session short but does not extend the reset.
        if (phase_expired) begin
          sweep_done = 1'b1;
          state_next = (abort_in || last_sweep) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        if (abort_in) begin
          state_next = S_RECOVER;
        end else if (phase_expired) begin
          state_next = S_START;
        end
      end
      S_DONE: begin
        if (!ctrl_busy_in) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      trigger_prev_q <= 1'b1;
      rst_hold_q     <= 1'b1;
      base_q         <= REGION0_BASE;
      remaining_q    <= '0;
      fail_count_q   <= '0;
    end else begin
      trigger_prev_q <= trigger_in;
      rst_hold_q     <= 1'b0;
      if ((state_q == S_IDLE) && trigger_rise) begin
        base_q      <= region_sel_in ? REGION1_BASE : REGION0_BASE;
        remaining_q <= (repeat_count_in == '0) ? REPEAT_BITS'(1) : repeat_count_in;
      end else if (abort_hit) begin
        remaining_q <= '0;
      end else if (sweep_done) begin
        remaining_q <= (remaining_q == '0) ? '0 : remaining_q - REPEAT_BITS'(1);
      end
      if (fail_event) begin
        fail_count_q <= sat_inc8(fail_count_q);
      end
    end
  end

  assign mem_address_out       = ctrl_address_in + base_q;
  assign ctrl_reset_out        = rst_hold_q | (state_q == S_RECOVER);
  assign ctrl_start_out        = (state_q == S_START);
  assign ctrl_loop_forever_out = 1'b0;
  assign busy_out              = (state_q != S_IDLE);
  assign led_out               = (state_q == S_RUN);
  assign done_strobe_out       = (state_q == S_DONE) && !ctrl_busy_in;
  assign fail_count_out        = fail_count_q;

endmodule
